// File: rtl/branch_unit.sv
// Branch resolution unit: owns the fetch PC, resolves conditional branches
// against the ALU's registered flags, and stalls one cycle when a branch
// arrives together with the ALU op whose flags it depends on.
module branch_unit #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_issue,
    input  logic                 zf,
    input  logic                 sf,
    input  logic                 of,
    input  logic                 pc_en,
    input  logic                 br_valid,
    input  logic [2:0]           br_cond,
    input  logic [PC_WIDTH-1:0]  br_target,
    output logic                 br_ready,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 fetch_valid,
    output logic                 taken,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    target_q, target_d;
    logic [2:0]             cond_q, cond_d;
    logic                   taken_q, taken_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    // Condition evaluation against the flags presented this cycle.
    function automatic logic cond_met(input logic [2:0] c, input logic z,
                                      input logic s, input logic o);
        logic lt;
        lt = s ^ o;
        case (c)
            3'b000:  cond_met = 1'b1;
            3'b001:  cond_met = z;
            3'b010:  cond_met = !z;
            3'b011:  cond_met = lt;
            3'b100:  cond_met = !lt;
            3'b101:  cond_met = !z && !lt;
            3'b110:  cond_met = z || lt;
            default: cond_met = 1'b0;
        endcase
    endfunction

    // Combinational handshake/fetch outputs, forced low while in reset.
    always_comb begin
        fetch_valid = !rst && (state_q == RUN);
        br_ready    = !rst && (state_q == RUN) && !alu_issue;
    end

    assign pc        = pc_q;
    assign taken     = taken_q;
    assign taken_cnt = cnt_q;

    // Next-state, PC and branch-resolution logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        cond_d   = cond_q;
        taken_d  = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            RUN: begin
                if (br_valid && !alu_issue) begin
                    if (cond_met(br_cond, zf, sf, of)) begin
                        pc_d    = br_target;
                        taken_d = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        state_d = FLUSH;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end else if (br_valid && alu_issue) begin
                    cond_d   = br_cond;
                    target_d = br_target;
                    state_d  = HOLD;
                end else if (pc_en) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            HOLD: begin
                if (cond_met(cond_q, zf, sf, of)) begin
                    pc_d    = target_q;
                    taken_d = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    state_d = FLUSH;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= '0;
            target_q <= '0;
            cond_q   <= '0;
            taken_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            cond_q   <= cond_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
